// File: rtl/pixel_palette_unit.sv
`default_nettype none
// ============================================================================
// Module   : pixel_palette_unit
// Purpose  : Maps mixed PPU pixels to RGB555 through BG/OBJ palette RAMs
//            (CGB) or the DMG shade registers, owns the CPU index/data
//            register pairs and runs a post-reset palette clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_palette_unit #(
  parameter int NUM_PAL = 8,
  parameter int DMG_RGB = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cpu_en_i,
  input  logic                       ppu_enable_i,
  input  logic                       ppu_mode3_i,
  input  logic                       cgb_i,
  input  logic [23:0]                dmg_palettes_i,
  input  logic                       pixel_valid_i,
  input  logic [$clog2(NUM_PAL)+2:0] mix_pixel_i,
  output logic [14:0]                pixel_color_o,
  output logic                       color_valid_o,
  output logic                       init_busy_o,
  input  logic [1:0]                 reg_sel_i,
  input  logic                       reg_write_i,
  input  logic [7:0]                 reg_wdata_i,
  output logic [7:0]                 reg_rdata_o
);

  localparam int PAL_BITS  = $clog2(NUM_PAL);
  localparam int ADDR_BITS = PAL_BITS + 3;
  localparam int PIX_BITS  = PAL_BITS + 3;
  localparam int RAM_DEPTH = 1 << ADDR_BITS;

  // A colour slot is two bytes, so the slot counter is one bit narrower.
  localparam logic [ADDR_BITS-2:0] LAST_SLOT = {(ADDR_BITS-1){1'b1}};
  localparam logic [ADDR_BITS-2:0] SLOT_ONE  = (ADDR_BITS-1)'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-2:0]   cnt_q, cnt_d;

  logic                   bg_ai_q, bg_ai_d, obj_ai_q, obj_ai_d;
  logic [ADDR_BITS-1:0]   bg_addr_q, bg_addr_d, obj_addr_q, obj_addr_d;

  logic [7:0]             bg_ram_q  [RAM_DEPTH];
  logic [7:0]             obj_ram_q [RAM_DEPTH];

  logic                   s1_valid_q, s1_cgb_q, s1_en_q;
  logic [PIX_BITS-1:0]    s1_pix_q;
  logic [1:0]             s1_shade_q;

  logic [14:0]            pixel_color_q, pixel_color_d;
  logic                   color_valid_q;

  logic                   w_wr, w_locked, w_store_ok;
  logic                   w_bg_idx_wr, w_bg_dat_wr, w_obj_idx_wr, w_obj_dat_wr;
  logic [7:0]             w_pal_byte;
  logic [1:0]             w_shade;
  logic [ADDR_BITS-2:0]   w_slot;
  logic [7:0]             w_lo;
  logic [6:0]             w_hi;
  logic [14:0]            w_dmg_color;
  logic [7:0]             w_bg_idx_rd, w_obj_idx_rd;

  assign init_busy_o   = (state_q == ST_INIT);
  assign pixel_color_o = pixel_color_q;
  assign color_valid_o = color_valid_q;

  // CPU access decode; palette data is locked while the PPU fetches pixels.
  assign w_wr         = cpu_en_i & reg_write_i;
  assign w_locked     = ppu_enable_i & ppu_mode3_i;
  assign w_store_ok   = ~w_locked & ~init_busy_o;
  assign w_bg_idx_wr  = w_wr & (reg_sel_i == 2'b00);
  assign w_bg_dat_wr  = w_wr & (reg_sel_i == 2'b01);
  assign w_obj_idx_wr = w_wr & (reg_sel_i == 2'b10);
  assign w_obj_dat_wr = w_wr & (reg_sel_i == 2'b11);

  // Sweep FSM next state: walk every colour slot once, then run forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + SLOT_ONE;
      if (cnt_q == LAST_SLOT) begin
        state_d = ST_RUN;
      end
    end
  end

  // Sweep FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Index registers: explicit index writes, or auto-increment on data writes
  // even when the store itself was blocked.
  always_comb begin
    bg_ai_d    = bg_ai_q;
    bg_addr_d  = bg_addr_q;
    obj_ai_d   = obj_ai_q;
    obj_addr_d = obj_addr_q;
    if (w_bg_idx_wr) begin
      bg_ai_d   = reg_wdata_i[7];
      bg_addr_d = reg_wdata_i[ADDR_BITS-1:0];
    end else if (w_bg_dat_wr && bg_ai_q) begin
      bg_addr_d = bg_addr_q + ADDR_ONE;
    end
    if (w_obj_idx_wr) begin
      obj_ai_d   = reg_wdata_i[7];
      obj_addr_d = reg_wdata_i[ADDR_BITS-1:0];
    end else if (w_obj_dat_wr && obj_ai_q) begin
      obj_addr_d = obj_addr_q + ADDR_ONE;
    end
  end

  // Index register storage.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      bg_ai_q    <= 1'b0;
      bg_addr_q  <= '0;
      obj_ai_q   <= 1'b0;
      obj_addr_q <= '0;
    end else begin
      bg_ai_q    <= bg_ai_d;
      bg_addr_q  <= bg_addr_d;
      obj_ai_q   <= obj_ai_d;
      obj_addr_q <= obj_addr_d;
    end
  end

  // Palette RAMs: the sweep owns both tables (white) until it completes,
  // after which only unlocked CPU data writes reach them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if (state_q == ST_INIT) begin
        bg_ram_q[{cnt_q, 1'b0}]  <= 8'hFF;
        bg_ram_q[{cnt_q, 1'b1}]  <= 8'h7F;
        obj_ram_q[{cnt_q, 1'b0}] <= 8'hFF;
        obj_ram_q[{cnt_q, 1'b1}] <= 8'h7F;
      end else begin
        if (w_bg_dat_wr && w_store_ok) begin
          bg_ram_q[bg_addr_q] <= reg_wdata_i;
        end
        if (w_obj_dat_wr && w_store_ok) begin
          obj_ram_q[obj_addr_q] <= reg_wdata_i;
        end
      end
    end
  end

  // DMG shade select: BGP for background, OBP0/OBP1 for objects; object
  // colour 0 is transparent and always yields shade 0.
  always_comb begin
    w_pal_byte = dmg_palettes_i[7:0];
    if (mix_pixel_i[PIX_BITS-1]) begin
      w_pal_byte = mix_pixel_i[2] ? dmg_palettes_i[23:16] : dmg_palettes_i[15:8];
    end
    case (mix_pixel_i[1:0])
      2'd0:    w_shade = w_pal_byte[1:0];
      2'd1:    w_shade = w_pal_byte[3:2];
      2'd2:    w_shade = w_pal_byte[5:4];
      default: w_shade = w_pal_byte[7:6];
    endcase
    if (mix_pixel_i[PIX_BITS-1] && (mix_pixel_i[1:0] == 2'd0)) begin
      w_shade = 2'd0;
    end
  end

  // Pipeline stage 1: capture the pixel and its context.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_cgb_q   <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_shade_q <= 2'd0;
    end else begin
      s1_valid_q <= pixel_valid_i;
      s1_pix_q   <= mix_pixel_i;
      s1_cgb_q   <= cgb_i;
      s1_en_q    <= ppu_enable_i;
      s1_shade_q <= w_shade;
    end
  end

  // CGB word fetch; the RAM is read before any same-edge CPU write lands.
  assign w_slot = s1_pix_q[PIX_BITS-2:0];
  assign w_lo   = s1_pix_q[PIX_BITS-1] ? obj_ram_q[{w_slot, 1'b0}]
                                       : bg_ram_q[{w_slot, 1'b0}];
  assign w_hi   = s1_pix_q[PIX_BITS-1] ? obj_ram_q[{w_slot, 1'b1}][6:0]
                                       : bg_ram_q[{w_slot, 1'b1}][6:0];

  generate
    if (DMG_RGB != 0) begin : g_dmg_grey
      // Shade to grey-level RGB555.
      always_comb begin
        case (s1_shade_q)
          2'd0:    w_dmg_color = 15'h7FFF;
          2'd1:    w_dmg_color = 15'h56B5;
          2'd2:    w_dmg_color = 15'h294A;
          default: w_dmg_color = 15'h0000;
        endcase
      end
    end else begin : g_dmg_raw
      assign w_dmg_color = {13'h0, s1_shade_q};
    end
  endgenerate

  // Output colour select with blanking during the sweep or with LCD off.
  always_comb begin
    pixel_color_d = s1_cgb_q ? {w_hi, w_lo} : w_dmg_color;
    if (init_busy_o || !s1_en_q) begin
      pixel_color_d = 15'h0000;
    end
  end

  // Pipeline stage 2: registered output.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pixel_color_q <= 15'h0000;
      color_valid_q <= 1'b0;
    end else begin
      pixel_color_q <= pixel_color_d;
      color_valid_q <= s1_valid_q;
    end
  end

  // CPU read mux: index reads show unused address bits as ones, data reads
  // return 0xFF while locked.
  always_comb begin
    w_bg_idx_rd                  = 8'h7F;
    w_bg_idx_rd[ADDR_BITS-1:0]   = bg_addr_q;
    w_bg_idx_rd[7]               = bg_ai_q;
    w_obj_idx_rd                 = 8'h7F;
    w_obj_idx_rd[ADDR_BITS-1:0]  = obj_addr_q;
    w_obj_idx_rd[7]              = obj_ai_q;
    case (reg_sel_i)
      2'b00:   reg_rdata_o = w_bg_idx_rd;
      2'b01:   reg_rdata_o = w_locked ? 8'hFF : bg_ram_q[bg_addr_q];
      2'b10:   reg_rdata_o = w_obj_idx_rd;
      default: reg_rdata_o = w_locked ? 8'hFF : obj_ram_q[obj_addr_q];
    endcase
  end

endmodule
`default_nettype wire
